divide_seq: RTL and testbench

Parametrised sequential restoring divider for the ALU. Computes one quotient bit per clock for WIDTH-bit signed or unsigned operands. Uses a start/busy/done handshake, so the ALU control logic can issue operations back-to-back. Holds its results until the next operation is accepted.

---
 rtl/divide_seq_if.sv | 24 ++
 rtl/divide_seq.sv | 123 ++++++++++++
 tb/tb_divide_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/divide_seq_if.sv
// Handshake and operand/result bundle for divide_seq.
interface divide_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divider;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, sign, dividend, divider,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, sign, dividend, divider,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/divide_seq.sv
// Sequential restoring divider, one quotient bit per clock, signed/unsigned.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations entirely.
module divide_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    divide_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   den_q, den_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remd_q, remd_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     diff;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        den_d      = den_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        quot_d     = quot_q;
        remd_d     = remd_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        a_mag = (bus.sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        b_mag = (bus.sign && bus.divider[WIDTH-1])  ? -bus.divider  : bus.divider;
        // Upper half after the shift, including the bit shifted out of the top.
        diff  = rem_q[2*WIDTH-1:WIDTH-1] - {1'b0, den_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    den_d   = b_mag;
                    rem_d   = {{WIDTH{1'b0}}, a_mag};
                    q_neg_d = bus.sign & (bus.dividend[WIDTH-1] ^ bus.divider[WIDTH-1]);
                    r_neg_d = bus.sign & bus.dividend[WIDTH-1];
                    dz_d    = (bus.divider == '0);
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
`ifdef DIV_ZERO_FAST_EN
                    // Preload the final layout so FINISH emits all-ones / raw dividend.
                    if (bus.divider == '0) begin
                        rem_d   = {bus.dividend, {WIDTH{1'b1}}};
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = FINISH;
                    end
`endif
                end
            end
            RUN: begin
                if (!diff[WIDTH]) begin
                    rem_d = {diff[WIDTH-1:0], rem_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                quot_d     = q_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                remd_d     = r_neg_q ? -rem_q[2*WIDTH-1:WIDTH] : rem_q[2*WIDTH-1:WIDTH];
                div_zero_d = dz_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            quot_q     <= '0;
            remd_q     <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dz_q       <= dz_d;
            quot_q     <= quot_d;
            remd_q     <= remd_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = remd_q;
    assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_divide_seq.sv
// Directed-vector bench for divide_seq at WIDTH=32 and WIDTH=8.
module tb_divide_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   ncyc;
    int   last_done;

    divide_seq_if #(.WIDTH(32)) b32 ();
    divide_seq_if #(.WIDTH(8))  b8 ();

    divide_seq #(.WIDTH(32)) u_div32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    divide_seq #(.WIDTH(8))  u_div8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
    localparam logic [31:0] NEGZ_Q = 32'hFFFF_FFFF;
`else
    localparam int ZLAT = 33;
    localparam logic [31:0] NEGZ_Q = 32'h0000_0001;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Issue one 32-bit op, wait for done (bounded), check latency and results.
    // poke>0 pulses start with other operands at that RUN cycle.
    task automatic run32(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat, input int poke);
        int          cyc;
        bit          seen;
        logic [31:0] q0;
        q0           = b32.quotient;
        b32.start    = 1'b1;
        b32.sign     = sg;
        b32.dividend = a;
        b32.divider  = b;
        @(posedge clk); #1;
        b32.start = 1'b0;
        check({tag, "_busy"}, b32.busy, 1);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            if (poke > 0 && cyc == poke) begin
                b32.start    = 1'b1;
                b32.sign     = 1'b0;
                b32.dividend = 32'd99;
                b32.divider  = 32'd9;
            end
            @(posedge clk); #1;
            b32.start = 1'b0;
            cyc++;
            if (b32.done) seen = 1;
            if (poke > 0 && cyc == poke + 2) check({tag, "_hold"}, b32.quotient, q0);
        end
        last_done = ncyc;
        check({tag, "_lat"}, cyc, elat);
        check({tag, "_q"}, b32.quotient, eq);
        check({tag, "_r"}, b32.remainder, er);
        check({tag, "_dz"}, b32.div_zero, edz);
        check({tag, "_nbusy"}, b32.busy, 0);
    endtask

    initial begin
        int d1;
        int cyc;
        bit seen;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        b32.start = 1'b0; b32.sign = 1'b0; b32.dividend = '0; b32.divider = '0;
        b8.start  = 1'b0; b8.sign  = 1'b0; b8.dividend  = '0; b8.divider  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", b32.quotient, 0);
        check("rst_r", b32.remainder, 0);
        check("rst_busy_done_dz", {b32.busy, b32.done, b32.div_zero}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run32("u10000", 0, 32'd10000, 32'd1000, 32'd10, 32'd0, 0, 33, 0);
        @(posedge clk); #1;
        check("done_pulse", b32.done, 0);

        run32("s_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33, 0);
        d1 = last_done;
        run32("s_7_m2", 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 33, 0);
        check("b2b_gap", last_done - d1, 34);

        run32("s_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 33, 0);
        run32("u_full", 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 33, 0);
        run32("u_div0", 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, ZLAT, 0);
        run32("s_negdiv0", 1, 32'hFFFF_FFFA, 32'd0, NEGZ_Q, 32'hFFFF_FFFA, 1, ZLAT, 0);
        run32("u100_3", 0, 32'd100, 32'd3, 32'd33, 32'd1, 0, 33, 0);
        run32("poke", 0, 32'd12345, 32'd100, 32'd123, 32'd45, 0, 33, 5);

        // Abort mid-run: outputs clear asynchronously and no done follows.
        b32.start = 1'b1; b32.sign = 1'b0; b32.dividend = 32'd500; b32.divider = 32'd7;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_q", b32.quotient, 0);
        check("abort_r", b32.remainder, 0);
        check("abort_busy_done_dz", {b32.busy, b32.done, b32.div_zero}, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (b32.done) seen = 1;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            if (b32.done) seen = 1;
        end
        check("abort_nodone", seen, 0);
        run32("post_rst", 0, 32'd500, 32'd7, 32'd71, 32'd3, 0, 33, 0);

        b8.start = 1'b1; b8.sign = 1'b0; b8.dividend = 8'd200; b8.divider = 8'd7;
        @(posedge clk); #1;
        b8.start = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (b8.done) seen = 1;
        end
        check("w8_lat", cyc, 9);
        check("w8_q", b8.quotient, 8'd28);
        check("w8_r", b8.remainder, 8'd4);
        check("w8_dz", b8.div_zero, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
